// File: rtl/truth_table_sweeper_if.sv
// Control/status bus of the truth-table sweeper: sweep request in, verdict and
// captured column out.
interface truth_table_sweeper_if #(
  parameter int N_IN = 4
);
  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [N_IN:0]          err_count;
  logic [N_IN-1:0]        first_err_vec;
  logic [(1<<N_IN)-1:0]   result;

  modport master (
    output start, abort,
    input  busy, done, pass, err_count, first_err_vec, result
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, err_count, first_err_vec, result
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives a combinational table through every input vector in ascending order,
// samples its output after HOLD cycles per vector and compares against EXPECT.
module truth_table_sweeper #(
  parameter int                   N_IN   = 4,
  parameter int                   HOLD   = 1,
  parameter logic [(1<<N_IN)-1:0] EXPECT = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  truth_table_sweeper_if.slave      bus,
  input  logic                      dut_out,
  output logic [N_IN-1:0]           dut_in
);
  localparam int            HW   = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] CMAX = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [HW-1:0] cnt;
  logic          mis;
  logic          hold_end;
  logic          last_vec;

  assign mis      = (dut_out != EXPECT[dut_in]);
  assign hold_end = (cnt == CMAX);
  assign last_vec = &dut_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      dut_in            <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.pass          <= 1'b0;
      bus.err_count     <= '0;
      bus.first_err_vec <= '0;
      bus.result        <= '0;
    end else begin
      case (state)
        IDLE: begin
          dut_in   <= '0;
          bus.done <= 1'b0;
          if (bus.start && !bus.abort) begin
            state             <= RUN;
            cnt               <= '0;
            bus.busy          <= 1'b1;
            bus.err_count     <= '0;
            bus.result        <= '0;
            bus.first_err_vec <= '0;
            bus.pass          <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
            dut_in   <= '0;
            bus.pass <= 1'b0;
          end else if (hold_end) begin
            cnt                <= '0;
            bus.result[dut_in] <= dut_out;
            if (mis) begin
              bus.err_count <= bus.err_count + (N_IN+1)'(1);
              // err_count still zero here means this is the sweep's first mismatch
              if (bus.err_count == '0) bus.first_err_vec <= dut_in;
            end
            if (last_vec) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.pass <= (bus.err_count == '0) && !mis;
            end else begin
              dut_in <= dut_in + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          dut_in   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweeper configurations, expected verdicts queued at
// start and compared by monitors whenever done pulses.
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pass;
    logic [4:0]  err;
    logic [3:0]  fev;
    logic [15:0] res;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  int   errors = 0;
  int   checks = 0;

  truth_table_sweeper_if #(.N_IN(3)) if3 ();
  truth_table_sweeper_if #(.N_IN(4)) if4 ();
  logic [2:0] din3;
  logic [3:0] din4;
  logic       dout3, dout4;
  int         mode = 0; // 0 majority, 1 inverted majority, 2 majority with vector 5 stuck at 0

  truth_table_sweeper #(.N_IN(3), .HOLD(1), .EXPECT(8'hE8)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .dut_out(dout3), .dut_in(din3));
  truth_table_sweeper #(.N_IN(4), .HOLD(3), .EXPECT(16'h8000)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4.slave), .dut_out(dout4), .dut_in(din4));

  always_comb begin
    logic maj;
    maj = (din3[2] & din3[1]) | (din3[2] & din3[0]) | (din3[1] & din3[0]);
    dout3 = maj;
    if (mode == 1) dout3 = ~maj;
    else if (mode == 2 && din3 == 3'd5) dout3 = 1'b0;
  end
  assign dout4 = &din4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if3.done === 1'b1) begin
      if (q3.size() == 0) chk("u3 unexpected done", 1, 0);
      else begin
        exp_t e;
        e = q3.pop_front();
        chk("u3 pass", {31'd0, if3.pass}, {31'd0, e.pass});
        chk("u3 err_count", {28'd0, if3.err_count}, {27'd0, e.err});
        chk("u3 first_err_vec", {29'd0, if3.first_err_vec}, {28'd0, e.fev});
        chk("u3 result", {24'd0, if3.result}, {16'd0, e.res});
      end
    end
    if (if4.done === 1'b1) begin
      if (q4.size() == 0) chk("u4 unexpected done", 1, 0);
      else begin
        exp_t e;
        e = q4.pop_front();
        chk("u4 pass", {31'd0, if4.pass}, {31'd0, e.pass});
        chk("u4 err_count", {27'd0, if4.err_count}, {27'd0, e.err});
        chk("u4 first_err_vec", {28'd0, if4.first_err_vec}, {28'd0, e.fev});
        chk("u4 result", {16'd0, if4.result}, {16'd0, e.res});
      end
    end
  end

  task automatic sweep3(input logic p, input logic [4:0] er, input logic [3:0] fv, input logic [15:0] rs);
    exp_t e;
    bit   seen;
    e.pass = p; e.err = er; e.fev = fv; e.res = rs;
    q3.push_back(e);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (if3.done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) chk("u3 done timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic all_zero3(input string nm);
    chk({nm, " dut_in"}, {29'd0, din3}, 0);
    chk({nm, " busy"}, {31'd0, if3.busy}, 0);
    chk({nm, " done"}, {31'd0, if3.done}, 0);
    chk({nm, " pass"}, {31'd0, if3.pass}, 0);
    chk({nm, " err_count"}, {28'd0, if3.err_count}, 0);
    chk({nm, " first_err_vec"}, {29'd0, if3.first_err_vec}, 0);
    chk({nm, " result"}, {24'd0, if3.result}, 0);
  endtask

  initial begin
    if3.start = 1'b0; if3.abort = 1'b0;
    if4.start = 1'b0; if4.abort = 1'b0;
    #1;
    all_zero3("reset");
    chk("reset u4 result", {16'd0, if4.result}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // majority pass, with per-cycle stepping
    begin
      exp_t e;
      e.pass = 1; e.err = 0; e.fev = 0; e.res = 16'h00E8;
      q3.push_back(e);
    end
    mode = 0;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    for (int v = 0; v < 8; v++) begin
      chk("maj dut_in step", {29'd0, din3}, v);
      chk("maj busy", {31'd0, if3.busy}, 1);
      @(negedge clk);
    end
    chk("maj done after 8", {31'd0, if3.done}, 1);
    chk("maj busy low at done", {31'd0, if3.busy}, 0);
    @(negedge clk);
    chk("maj done one cycle", {31'd0, if3.done}, 0);
    chk("maj results hold", {24'd0, if3.result}, 32'hE8);

    mode = 1;
    sweep3(0, 5'd8, 4'd0, 16'h0017);
    mode = 2;
    sweep3(0, 5'd1, 4'd5, 16'h00C8);

    // hold length: each vector held 3 cycles, busy for 48
    begin
      exp_t e;
      e.pass = 1; e.err = 0; e.fev = 0; e.res = 16'h8000;
      q4.push_back(e);
    end
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    for (int k = 0; k < 48; k++) begin
      chk("hold dut_in", {28'd0, din4}, k / 3);
      chk("hold busy", {31'd0, if4.busy}, 1);
      @(negedge clk);
    end
    chk("hold done", {31'd0, if4.done}, 1);
    chk("hold busy end", {31'd0, if4.busy}, 0);
    @(negedge clk);

    // abort at vector 3 with inverted table; start during RUN ignored
    mode = 1;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    @(negedge clk);
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    chk("start in RUN ignored", {29'd0, din3}, 2);
    @(negedge clk);
    chk("abort at vec3", {29'd0, din3}, 3);
    if3.abort = 1'b1;
    @(negedge clk);
    if3.abort = 1'b0;
    chk("abort busy", {31'd0, if3.busy}, 0);
    chk("abort dut_in", {29'd0, din3}, 0);
    chk("abort pass", {31'd0, if3.pass}, 0);
    chk("abort done", {31'd0, if3.done}, 0);
    chk("abort partial err", {28'd0, if3.err_count}, 3);
    chk("abort partial result", {24'd0, if3.result}, 32'h07);
    chk("abort partial fev", {29'd0, if3.first_err_vec}, 0);
    repeat (3) @(negedge clk);
    chk("abort stays idle", {31'd0, if3.busy}, 0);

    // start with abort in IDLE
    if3.start = 1'b1; if3.abort = 1'b1;
    @(negedge clk);
    if3.start = 1'b0; if3.abort = 1'b0;
    chk("start+abort no sweep", {31'd0, if3.busy}, 0);
    @(negedge clk);
    chk("start+abort still idle", {31'd0, if3.busy}, 0);

    // reset mid-sweep, then fresh sweep
    mode = 1;
    if3.start = 1'b1;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre-reset err nonzero", {28'd0, if3.err_count}, 4);
    #2 rst_n = 1'b0;
    #1;
    all_zero3("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-reset idle", {31'd0, if3.busy}, 0);
    mode = 0;
    sweep3(1, 5'd0, 4'd0, 16'h00E8);

    repeat (3) @(negedge clk);
    chk("u3 queue drained", q3.size(), 0);
    chk("u4 queue drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end
endmodule
